cam_pen_filter: RTL and testbench
=================================

// Module: cam_pen_filter
// PURPOSE
//   Downstream of the IR-camera I2C reader. Takes each raw 11-bit blob position
//   (1024x768 camera space), rejects "no blob" samples, smooths with a first-order
//   IIR filter and scales to 640x480 screen coordinates. Result drives the pen
//   position and pen-down state used by the drawing/framebuffer logic.
// PARAMETERS
//   FILT_LOG2  2   IIR shift K; new avg weight = 1/2^K (0 = no filtering)
//   MISS_LIMIT 3   consecutive invalid samples before pen_down drops (1..15)
//   MIRROR_X   0   1: pen_x = 639 - scaled x (camera faces the screen)
// PORTS
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high reset
//   cam_x       in   11  raw camera x, held stable while cam_strobe is high
//   cam_y       in   11  raw camera y, held stable while cam_strobe is high
//   cam_strobe  in   1   one-cycle pulse: new cam_x/cam_y sample present
//   pen_x       out  10  screen x, 0..639
//   pen_y       out  10  screen y, 0..479
//   pen_valid   out  1   one-cycle pulse: pen_x/pen_y updated
//   pen_down    out  1   blob currently tracked
//   busy        out  1   sample in flight; cam_strobe ignored while high
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset: all outputs 0, FSM in S_IDLE, accumulators 0, miss counter 0.
//   FSM: S_IDLE -> S_CHECK -> S_FILTER -> S_SCALE -> S_OUT -> S_IDLE, one state per cycle.
//   - S_IDLE: on cam_strobe, latch cam_x/cam_y; otherwise stay.
//   - S_CHECK: sample invalid if x>=1023 or y>=1023.
//   - S_FILTER, valid sample: if pen_down==0, preload acc = s<<K; else acc = acc - (acc>>K) + s.
//     One acc each for x and y, (11+K) bits wide; avg = acc>>K. Then miss=0, pen_down=1.
//   - S_FILTER, invalid sample: acc unchanged; miss counter increments, saturating at
//     MISS_LIMIT. When it reaches MISS_LIMIT, pen_down=0 (same cycle).
//   - S_SCALE: sx = (avg_x*5)>>3, sy = (avg_y*5)>>3, floor. Clamp sx to 639, sy to 479.
//     If MIRROR_X, sx = 639 - sx after the clamp.
//   - S_OUT: valid sample only: pen_x/pen_y load, pen_valid=1 for this cycle.
//     Invalid sample: no pulse; pen_x/pen_y keep the last value.
//   Latency: cam_strobe high in cycle T (S_IDLE) -> pen_valid high in cycle T+4.
//     busy high T+1..T+4. New strobe accepted from T+5.
//   cam_strobe while busy: dropped silently; no effect on state.
//   Reset mid-operation: return to S_IDLE next cycle; no pen_valid pulse.
//     pen_down=0, so the next valid sample preloads.
//   pen_down changes only in S_FILTER; pen_x/pen_y change only in S_OUT.
// TESTING
//   1 Reset 3 cycles, no strobe -> all outputs 0, busy 0.
//   2 K=2, strobe x=512,y=384 at T -> pen_valid only at T+4; pen_x=320, pen_y=240, pen_down=1.
//   3 Follow with x=1000,y=384 -> acc_x=2536, avg 634; pen_x=396, pen_y=240.
//   4 After 2, three strobes x=1023 -> no pen_valid; pen_down 1,1,then 0 at 3rd S_FILTER.
//     Then x=100,y=100 -> preload; pen_x=62, pen_y=62.
//   5 y=1000 valid -> sy=625 clamps to 479. MIRROR_X=1 with x=0 -> pen_x=639.
//   6 Strobe at T+2 -> ignored, single pulse. Reset at T+2 -> no pulse, outputs 0, idle at T+3.

Source files
------------

// File: rtl/cam_pen_filter.sv
// cam_pen_filter: validates raw IR-camera blob positions, smooths them with a
// first-order IIR filter and scales 1024x768 camera space to 640x480 screen.
module cam_pen_filter #(
  parameter int FILT_LOG2  = 2,
  parameter int MISS_LIMIT = 3,
  parameter int MIRROR_X   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] cam_x,
  input  logic [10:0] cam_y,
  input  logic        cam_strobe,
  output logic [9:0]  pen_x,
  output logic [9:0]  pen_y,
  output logic        pen_valid,
  output logic        pen_down,
  output logic        busy
);

  localparam int AW = 11 + FILT_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FILTER,
    S_SCALE,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [10:0]     samp_x_q, samp_x_d;
  logic [10:0]     samp_y_q, samp_y_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   acc_x_q, acc_x_d;
  logic [AW-1:0]   acc_y_q, acc_y_d;
  logic [3:0]      miss_q, miss_d;
  logic            pen_down_q, pen_down_d;
  logic [9:0]      pen_x_q, pen_x_d;
  logic [9:0]      pen_y_q, pen_y_d;
  logic            pen_valid_q, pen_valid_d;

  logic [10:0]     avg_x, avg_y;
  logic [10:0]     sx_raw, sy_raw;
  logic [9:0]      sx_clamp, sy_clamp, sx_final;

  // Average, scale by 5/8 (floor), clamp to screen, optional horizontal mirror.
  always_comb begin
    avg_x    = 11'(acc_x_q >> FILT_LOG2);
    avg_y    = 11'(acc_y_q >> FILT_LOG2);
    sx_raw   = 11'((14'(avg_x) * 14'd5) >> 3);
    sy_raw   = 11'((14'(avg_y) * 14'd5) >> 3);
    sx_clamp = (sx_raw > 11'd639) ? 10'd639 : sx_raw[9:0];
    sy_clamp = (sy_raw > 11'd479) ? 10'd479 : sy_raw[9:0];
    sx_final = (MIRROR_X != 0) ? (10'd639 - sx_clamp) : sx_clamp;
  end

  // Sequencing and datapath next-state logic.
  always_comb begin
    state_d     = state_q;
    samp_x_d    = samp_x_q;
    samp_y_d    = samp_y_q;
    valid_d     = valid_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    miss_d      = miss_q;
    pen_down_d  = pen_down_q;
    pen_x_d     = pen_x_q;
    pen_y_d     = pen_y_q;
    pen_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cam_strobe) begin
          samp_x_d = cam_x;
          samp_y_d = cam_y;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        valid_d = (samp_x_q < 11'd1023) && (samp_y_q < 11'd1023);
        state_d = S_FILTER;
      end
      S_FILTER: begin
        if (valid_q) begin
          if (!pen_down_q) begin
            acc_x_d = AW'(samp_x_q) << FILT_LOG2;
            acc_y_d = AW'(samp_y_q) << FILT_LOG2;
          end else begin
            acc_x_d = acc_x_q - (acc_x_q >> FILT_LOG2) + AW'(samp_x_q);
            acc_y_d = acc_y_q - (acc_y_q >> FILT_LOG2) + AW'(samp_y_q);
          end
          miss_d     = '0;
          pen_down_d = 1'b1;
        end else begin
          if (miss_q < 4'(MISS_LIMIT)) miss_d = miss_q + 4'd1;
          if (miss_d == 4'(MISS_LIMIT)) pen_down_d = 1'b0;
        end
        state_d = S_SCALE;
      end
      S_SCALE: begin
        // Outputs are registered here so they are visible throughout S_OUT,
        // together with the pen_valid pulse.
        if (valid_q) begin
          pen_x_d     = sx_final;
          pen_y_d     = sy_clamp;
          pen_valid_d = 1'b1;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      samp_x_q    <= '0;
      samp_y_q    <= '0;
      valid_q     <= 1'b0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      miss_q      <= '0;
      pen_down_q  <= 1'b0;
      pen_x_q     <= '0;
      pen_y_q     <= '0;
      pen_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_x_q    <= samp_x_d;
      samp_y_q    <= samp_y_d;
      valid_q     <= valid_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      miss_q      <= miss_d;
      pen_down_q  <= pen_down_d;
      pen_x_q     <= pen_x_d;
      pen_y_q     <= pen_y_d;
      pen_valid_q <= pen_valid_d;
    end
  end

  assign pen_x     = pen_x_q;
  assign pen_y     = pen_y_q;
  assign pen_valid = pen_valid_q;
  assign pen_down  = pen_down_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cam_pen_filter.sv
// tb_cam_pen_filter: directed tests for cam_pen_filter, with a second instance
// built with MIRROR_X=1 sharing the same stimulus.
module tb_cam_pen_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] cam_x = '0;
  logic [10:0] cam_y = '0;
  logic        cam_strobe = 1'b0;
  logic [9:0]  pen_x, pen_y, pen_x_m, pen_y_m;
  logic        pen_valid, pen_down, busy;
  logic        pen_valid_m, pen_down_m, busy_m;

  int checks = 0;
  int errors = 0;

  // Per-cycle observations of the last transaction (index = cycles after strobe).
  logic       vseen [0:8];
  logic       bseen [0:8];
  logic [9:0] xseen [0:8];
  logic [9:0] yseen [0:8];
  logic       dseen [0:8];
  logic [9:0] xmseen [0:8];
  int         pulses;
  int         first_pulse;

  cam_pen_filter #(.FILT_LOG2(2), .MISS_LIMIT(3), .MIRROR_X(0)) dut (
    .clk(clk), .reset(reset), .cam_x(cam_x), .cam_y(cam_y), .cam_strobe(cam_strobe),
    .pen_x(pen_x), .pen_y(pen_y), .pen_valid(pen_valid), .pen_down(pen_down), .busy(busy)
  );

  cam_pen_filter #(.FILT_LOG2(2), .MISS_LIMIT(3), .MIRROR_X(1)) dut_m (
    .clk(clk), .reset(reset), .cam_x(cam_x), .cam_y(cam_y), .cam_strobe(cam_strobe),
    .pen_x(pen_x_m), .pen_y(pen_y_m), .pen_valid(pen_valid_m), .pen_down(pen_down_m),
    .busy(busy_m)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    cam_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Strobe one sample at cycle T; optionally strobe again or assert reset at
  // cycle T+inject_at / T+reset_at. Records outputs for cycles T..T+8.
  task automatic run(input logic [10:0] x, input logic [10:0] y,
                     input int inject_at, input int reset_at);
    pulses = 0;
    first_pulse = -1;
    @(posedge clk); #1;
    cam_x = x;
    cam_y = y;
    cam_strobe = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      vseen[c] = pen_valid;
      bseen[c] = busy;
      xseen[c] = pen_x;
      yseen[c] = pen_y;
      dseen[c] = pen_down;
      xmseen[c] = pen_x_m;
      if (pen_valid === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c;
      end
      @(posedge clk); #1;
      cam_strobe = (c + 1 == inject_at);
      reset = (c + 1 == reset_at);
      if (c + 1 == inject_at) begin
        cam_x = 11'd100;
        cam_y = 11'd100;
      end
    end
    reset = 1'b0;
    cam_strobe = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({pen_x, pen_y, pen_valid, pen_down, busy} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d v=%b d=%b busy=%b, want all 0",
               pen_x, pen_y, pen_valid, pen_down, busy);
    end
    checks++;
    if ({pen_x_m, pen_valid_m, pen_down_m, busy_m} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs_mirror: got x=%0d v=%b d=%b busy=%b, want all 0",
               pen_x_m, pen_valid_m, pen_down_m, busy_m);
    end
  endtask

  task automatic test_first_sample();
    run(11'd512, 11'd384, -1, -1);
    checks++;
    if (pulses != 1 || first_pulse != 4) begin
      errors++;
      $display("FAIL latency: got pulses=%0d at T+%0d, want 1 at T+4", pulses, first_pulse);
    end
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (bseen[c] !== (c >= 1 && c <= 4)) begin
        errors++;
        $display("FAIL busy_T+%0d: got %b, want %b", c, bseen[c], (c >= 1 && c <= 4));
      end
    end
    checks++;
    if (xseen[4] !== 10'd320 || yseen[4] !== 10'd240 || dseen[4] !== 1'b1) begin
      errors++;
      $display("FAIL first_sample: got x=%0d y=%0d d=%b, want x=320 y=240 d=1",
               xseen[4], yseen[4], dseen[4]);
    end
    checks++;
    if (xmseen[4] !== 10'd319) begin
      errors++;
      $display("FAIL first_sample_mirror: got x=%0d, want 319", xmseen[4]);
    end
  endtask

  task automatic test_filter();
    run(11'd1000, 11'd384, -1, -1);
    checks++;
    if (pulses != 1 || xseen[4] !== 10'd396 || yseen[4] !== 10'd240) begin
      errors++;
      $display("FAIL filter_step: got pulses=%0d x=%0d y=%0d, want 1 396 240",
               pulses, xseen[4], yseen[4]);
    end
  endtask

  task automatic test_miss();
    logic exp_down [0:2];
    exp_down[0] = 1'b1;
    exp_down[1] = 1'b1;
    exp_down[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run(11'd1023, 11'd384, -1, -1);
      checks++;
      if (pulses != 0 || pen_down !== exp_down[i] || pen_x !== 10'd396 || pen_y !== 10'd240) begin
        errors++;
        $display("FAIL miss_%0d: got pulses=%0d d=%b x=%0d y=%0d, want 0 %b 396 240",
                 i, pulses, pen_down, pen_x, pen_y, exp_down[i]);
      end
    end
    run(11'd100, 11'd100, -1, -1);
    checks++;
    if (pulses != 1 || xseen[4] !== 10'd62 || yseen[4] !== 10'd62 || dseen[4] !== 1'b1) begin
      errors++;
      $display("FAIL miss_preload: got pulses=%0d x=%0d y=%0d d=%b, want 1 62 62 1",
               pulses, xseen[4], yseen[4], dseen[4]);
    end
  endtask

  task automatic test_clamp_mirror();
    do_reset();
    run(11'd1022, 11'd1000, -1, -1);
    checks++;
    if (pulses != 1 || xseen[4] !== 10'd638 || yseen[4] !== 10'd479) begin
      errors++;
      $display("FAIL clamp_y: got pulses=%0d x=%0d y=%0d, want 1 638 479",
               pulses, xseen[4], yseen[4]);
    end
    checks++;
    if (xmseen[4] !== 10'd1) begin
      errors++;
      $display("FAIL mirror_638: got x=%0d, want 1", xmseen[4]);
    end
    do_reset();
    run(11'd0, 11'd0, -1, -1);
    checks++;
    if (pulses != 1 || xmseen[4] !== 10'd639 || xseen[4] !== 10'd0) begin
      errors++;
      $display("FAIL mirror_zero: got pulses=%0d xm=%0d x=%0d, want 1 639 0",
               pulses, xmseen[4], xseen[4]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run(11'd512, 11'd384, 2, -1);
    checks++;
    if (pulses != 1 || first_pulse != 4 || xseen[8] !== 10'd320 || yseen[8] !== 10'd240) begin
      errors++;
      $display("FAIL busy_strobe_drop: got pulses=%0d at T+%0d x=%0d y=%0d, want 1 at T+4 320 240",
               pulses, first_pulse, xseen[8], yseen[8]);
    end
  endtask

  task automatic test_reset_mid();
    run(11'd1000, 11'd384, -1, 2);
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_pulse: got %0d pulses, want 0", pulses);
    end
    checks++;
    if (bseen[3] !== 1'b0 || xseen[3] !== 10'd0 || yseen[3] !== 10'd0 || dseen[3] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: got busy=%b x=%0d y=%0d d=%b, want 0 0 0 0",
               bseen[3], xseen[3], yseen[3], dseen[3]);
    end
    run(11'd100, 11'd100, -1, -1);
    checks++;
    if (pulses != 1 || xseen[4] !== 10'd62 || yseen[4] !== 10'd62) begin
      errors++;
      $display("FAIL reset_mid_preload: got pulses=%0d x=%0d y=%0d, want 1 62 62",
               pulses, xseen[4], yseen[4]);
    end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_filter();
    test_miss();
    test_clamp_mirror();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
